// File: rtl/read_pointer_handler_if.sv
// ----------------------------------------------------------------------------
// read_pointer_handler_if
// Groups the read-side signals of the FIFO read-pointer block.
//   master : FIFO read client / testbench (drives R_INC, g_wptr, UF_CLR)
//   slave  : read_pointer_handler (drives pointers, flags and count)
// Signals:
//   R_INC     read request
//   g_wptr    Gray write pointer from the write clock domain (unsynchronized)
//   b_rptr    binary read pointer, low PTR_WIDTH-1 bits address the RAM
//   g_rptr    registered Gray read pointer for the write clock domain
//   EMPTY     FIFO empty
//   AEMPTY    FIFO almost empty
//   RD_COUNT  occupancy seen from the read domain
//   RD_VALID  read accepted this cycle
//   UF_CLR    clears UNDERFLOW      (only with FIFO_RD_UNDERFLOW_EN)
//   UNDERFLOW sticky underflow flag (only with FIFO_RD_UNDERFLOW_EN)
// Optional feature macro: FIFO_RD_UNDERFLOW_EN
// ----------------------------------------------------------------------------
interface read_pointer_handler_if #(
  parameter int PTR_WIDTH = 4
);
  logic                 R_INC;
  logic [PTR_WIDTH-1:0] g_wptr;
  logic [PTR_WIDTH-1:0] b_rptr;
  logic [PTR_WIDTH-1:0] g_rptr;
  logic                 EMPTY;
  logic                 AEMPTY;
  logic [PTR_WIDTH-1:0] RD_COUNT;
  logic                 RD_VALID;
`ifdef FIFO_RD_UNDERFLOW_EN
  logic                 UF_CLR;
  logic                 UNDERFLOW;

  modport master (
    output R_INC, g_wptr, UF_CLR,
    input  b_rptr, g_rptr, EMPTY, AEMPTY, RD_COUNT, RD_VALID, UNDERFLOW
  );
  modport slave (
    input  R_INC, g_wptr, UF_CLR,
    output b_rptr, g_rptr, EMPTY, AEMPTY, RD_COUNT, RD_VALID, UNDERFLOW
  );
`else
  modport master (
    output R_INC, g_wptr,
    input  b_rptr, g_rptr, EMPTY, AEMPTY, RD_COUNT, RD_VALID
  );
  modport slave (
    input  R_INC, g_wptr,
    output b_rptr, g_rptr, EMPTY, AEMPTY, RD_COUNT, RD_VALID
  );
`endif
endinterface

// File: rtl/read_pointer_handler.sv
// ----------------------------------------------------------------------------
// read_pointer_handler
// Read-side pointer logic of an asynchronous FIFO: synchronizes the Gray
// write pointer into the read clock domain, keeps the binary and Gray read
// pointers, and derives EMPTY / AEMPTY / RD_COUNT / RD_VALID.
// Ports:
//   R_CLK  read-domain clock (rising edge)
//   R_RST  asynchronous active-high reset
//   bus    read_pointer_handler_if.slave (see interface header)
// Parameters:
//   PTR_WIDTH      pointer width, FIFO depth = 2**(PTR_WIDTH-1)
//   SYNC_STAGES    write-pointer synchronizer depth (>= 2)
//   AEMPTY_THRESH  AEMPTY asserts when RD_COUNT <= this value
// Optional feature macro: FIFO_RD_UNDERFLOW_EN adds UF_CLR / UNDERFLOW.
// ----------------------------------------------------------------------------
module read_pointer_handler #(
  parameter int PTR_WIDTH     = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int AEMPTY_THRESH = 1
) (
  input logic                    R_CLK,
  input logic                    R_RST,
  read_pointer_handler_if.slave  bus
);

  localparam logic [PTR_WIDTH-1:0] AEMPTY_LVL = PTR_WIDTH'(AEMPTY_THRESH);
  localparam logic [PTR_WIDTH-1:0] PTR_ONE    = PTR_WIDTH'(1);

  logic [PTR_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [PTR_WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [PTR_WIDTH-1:0] b_rptr_q, b_rptr_d;
  logic [PTR_WIDTH-1:0] g_rptr_q, g_rptr_d;

  logic [PTR_WIDTH-1:0] g_wptr_sync;
  logic [PTR_WIDTH-1:0] b_wptr_sync;
  logic [PTR_WIDTH-1:0] rd_count;
  logic                 empty;
  logic                 rd_valid;

`ifdef FIFO_RD_UNDERFLOW_EN
  logic underflow_q, underflow_d;
`endif

  // Flags are derived only from registered values so no unsynchronized
  // write-domain bit can reach EMPTY combinationally.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    sync_d[0] = bus.g_wptr;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];

    g_wptr_sync = sync_q[SYNC_STAGES-1];

    // Gray to binary: each bit is the XOR of itself and every bit above it.
    b_wptr_sync[PTR_WIDTH-1] = g_wptr_sync[PTR_WIDTH-1];
    for (int i = PTR_WIDTH - 2; i >= 0; i--)
      b_wptr_sync[i] = b_wptr_sync[i+1] ^ g_wptr_sync[i];

    // Modulo-2**PTR_WIDTH difference; the wrap bit keeps full vs empty apart.
    rd_count = b_wptr_sync - b_rptr_q;
    empty    = (g_rptr_q == g_wptr_sync);
    rd_valid = bus.R_INC && !empty;

    b_rptr_d = rd_valid ? (b_rptr_q + PTR_ONE) : b_rptr_q;
    g_rptr_d = b_rptr_d ^ (b_rptr_d >> 1);

`ifdef FIFO_RD_UNDERFLOW_EN
    // Set has priority over clear when both happen in the same cycle.
    underflow_d = underflow_q;
    if (bus.UF_CLR)             underflow_d = 1'b0;
    if (bus.R_INC && empty)     underflow_d = 1'b1;
`endif
  end

  always_ff @(posedge R_CLK or posedge R_RST) begin
    if (R_RST) begin
      // NOTE: the synchronizer chain is reset (unlike a data memory) because its contents decide EMPTY right after reset release.
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      b_rptr_q <= '0;
      g_rptr_q <= '0;
`ifdef FIFO_RD_UNDERFLOW_EN
      underflow_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values and the chain shifts one stage per edge.
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
      b_rptr_q <= b_rptr_d;
      g_rptr_q <= g_rptr_d;
`ifdef FIFO_RD_UNDERFLOW_EN
      underflow_q <= underflow_d;
`endif
    end
  end

  assign bus.b_rptr   = b_rptr_q;
  assign bus.g_rptr   = g_rptr_q;
  assign bus.EMPTY    = empty;
  assign bus.AEMPTY   = (rd_count <= AEMPTY_LVL);
  assign bus.RD_COUNT = rd_count;
  assign bus.RD_VALID = rd_valid;
`ifdef FIFO_RD_UNDERFLOW_EN
  assign bus.UNDERFLOW = underflow_q;
`endif

endmodule

// File: tb/tb_read_pointer_handler.sv
// ----------------------------------------------------------------------------
// tb_read_pointer_handler
// Directed and randomized stimulus for read_pointer_handler (PTR_WIDTH=4,
// SYNC_STAGES=2, AEMPTY_THRESH=1). Expected values come from a reference
// model holding the read pointer as an integer and the write pointer history
// as a queue; occupancy is plain modular subtraction.
// Optional feature macro: FIFO_RD_UNDERFLOW_EN
// ----------------------------------------------------------------------------
module tb_read_pointer_handler;

  localparam int W    = 4;
  localparam int SYNC = 2;
  localparam int THR  = 1;
  localparam int MOD  = 1 << W;

  logic R_CLK = 1'b0;
  logic R_RST;

  read_pointer_handler_if #(.PTR_WIDTH(W)) bus ();

  read_pointer_handler #(
    .PTR_WIDTH    (W),
    .SYNC_STAGES  (SYNC),
    .AEMPTY_THRESH(THR)
  ) dut (
    .R_CLK(R_CLK),
    .R_RST(R_RST),
    .bus  (bus)
  );

  always #5 R_CLK = ~R_CLK;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int         m_rptr;
  logic [W-1:0] m_hist[$];
`ifdef FIFO_RD_UNDERFLOW_EN
  bit         m_uf;
`endif

  function automatic int gray(int b);
    return (b ^ (b >> 1)) % MOD;
  endfunction

  function automatic int g2b(logic [W-1:0] g);
    int b = 0;
    for (int s = 0; s < W; s++) b = b ^ (int'(g) >> s);
    return b;
  endfunction

  // Write pointer as seen by the read domain: the value sampled SYNC edges ago.
  function automatic int m_count();
    return (g2b(m_hist[0]) - m_rptr + MOD) % MOD;
  endfunction

  task automatic model_reset();
    m_rptr = 0;
    m_hist.delete();
    repeat (SYNC) m_hist.push_back('0);
`ifdef FIFO_RD_UNDERFLOW_EN
    m_uf = 1'b0;
`endif
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply the model's view of one rising edge, then advance to just after it.
  task automatic tick();
    int  cnt;
    bit  emp;
    cnt = m_count();
    emp = (cnt == 0);
    if (!R_RST) begin
      if (bus.R_INC && !emp) m_rptr = (m_rptr + 1) % MOD;
`ifdef FIFO_RD_UNDERFLOW_EN
      if (bus.R_INC && emp) m_uf = 1'b1;
      else if (bus.UF_CLR)  m_uf = 1'b0;
`endif
      m_hist.push_back(bus.g_wptr);
      void'(m_hist.pop_front());
    end
    @(posedge R_CLK);
    #1;
  endtask

  task automatic check_all(input string tag);
    int cnt;
    cnt = m_count();
    chk({tag, ".b_rptr"},   bus.b_rptr,   m_rptr);
    chk({tag, ".g_rptr"},   bus.g_rptr,   gray(m_rptr));
    chk({tag, ".EMPTY"},    bus.EMPTY,    (cnt == 0));
    chk({tag, ".AEMPTY"},   bus.AEMPTY,   (cnt <= THR));
    chk({tag, ".RD_COUNT"}, bus.RD_COUNT, cnt);
    chk({tag, ".RD_VALID"}, bus.RD_VALID, (!R_RST && bus.R_INC && cnt != 0));
`ifdef FIFO_RD_UNDERFLOW_EN
    chk({tag, ".UNDERFLOW"}, bus.UNDERFLOW, m_uf);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wbin;

    // Power-on reset
    R_RST      = 1'b1;
    bus.R_INC  = 1'b0;
    bus.g_wptr = '0;
`ifdef FIFO_RD_UNDERFLOW_EN
    bus.UF_CLR = 1'b0;
`endif
    model_reset();
    #2;
    check_all("por");
    @(negedge R_CLK);
    R_RST = 1'b0;
    tick();
    check_all("post_por");

    // Latency: write of 3 entries becomes visible exactly 2 edges later
    bus.g_wptr = 4'b0010;
    tick();
    chk("lat_edge1.EMPTY", bus.EMPTY, 1'b1);
    check_all("lat_edge1");
    tick();
    chk("lat_edge2.EMPTY",    bus.EMPTY,    1'b0);
    chk("lat_edge2.RD_COUNT", bus.RD_COUNT, 3);
    chk("lat_edge2.AEMPTY",   bus.AEMPTY,   1'b0);
    check_all("lat_edge2");

    // Drain three entries
    bus.R_INC = 1'b1;
    repeat (3) begin
      #1 chk("drain.RD_VALID", bus.RD_VALID, 1'b1);
      tick();
      check_all("drain");
    end
    chk("drained.b_rptr",   bus.b_rptr,   3);
    chk("drained.g_rptr",   bus.g_rptr,   4'b0010);
    chk("drained.EMPTY",    bus.EMPTY,    1'b1);
    chk("drained.RD_COUNT", bus.RD_COUNT, 0);

    // Read on empty: ignored, underflow sets (set wins over clear)
    #1 chk("uf.RD_VALID", bus.RD_VALID, 1'b0);
    tick();
    chk("uf.b_rptr", bus.b_rptr, 3);
    check_all("uf_set");
`ifdef FIFO_RD_UNDERFLOW_EN
    chk("uf_set.UNDERFLOW", bus.UNDERFLOW, 1'b1);
    bus.UF_CLR = 1'b1;
    tick();
    chk("uf_set_wins.UNDERFLOW", bus.UNDERFLOW, 1'b1);
    bus.R_INC = 1'b0;
    tick();
    chk("uf_clr.UNDERFLOW", bus.UNDERFLOW, 1'b0);
    bus.UF_CLR = 1'b0;
    bus.R_INC  = 1'b1;
    tick();
    check_all("uf_reset_prep");
`endif
    bus.R_INC = 1'b0;

    // Asynchronous reset pulse between edges
    #2 R_RST = 1'b1;
    model_reset();
    #1;
    chk("arst.b_rptr",   bus.b_rptr,   0);
    chk("arst.g_rptr",   bus.g_rptr,   0);
    chk("arst.EMPTY",    bus.EMPTY,    1'b1);
    chk("arst.AEMPTY",   bus.AEMPTY,   1'b1);
    chk("arst.RD_COUNT", bus.RD_COUNT, 0);
`ifdef FIFO_RD_UNDERFLOW_EN
    chk("arst.UNDERFLOW", bus.UNDERFLOW, 1'b0);
`endif
    #1 R_RST = 1'b0;

    // Full occupancy: writer at gray 8
    bus.g_wptr = 4'b1100;
    tick();
    tick();
    chk("full.RD_COUNT", bus.RD_COUNT, 8);
    chk("full.EMPTY",    bus.EMPTY,    1'b0);
    chk("full.AEMPTY",   bus.AEMPTY,   1'b0);
    check_all("full");
    bus.R_INC = 1'b1;
    repeat (8) begin tick(); check_all("drain8"); end
    bus.R_INC = 1'b0;

    // Advance reader to 14 ahead of the wrap
    bus.g_wptr = 4'b1001;
    tick();
    tick();
    check_all("pre_wrap");
    bus.R_INC = 1'b1;
    repeat (6) begin tick(); check_all("to14"); end
    bus.R_INC = 1'b0;
    chk("at14.b_rptr", bus.b_rptr, 14);

    // Wrap: writer wrapped to 0, two reads cross the boundary
    bus.g_wptr = 4'b0000;
    tick();
    tick();
    chk("wrap.RD_COUNT", bus.RD_COUNT, 2);
    bus.R_INC = 1'b1;
    tick();
    chk("wrap1.b_rptr", bus.b_rptr, 15);
    chk("wrap1.g_rptr", bus.g_rptr, 4'b1000);
    tick();
    chk("wrap2.b_rptr", bus.b_rptr, 0);
    chk("wrap2.g_rptr", bus.g_rptr, 4'b0000);
    chk("wrap2.EMPTY",  bus.EMPTY,  1'b1);
    check_all("wrap2");
    bus.R_INC = 1'b0;

    // Mid-operation reset with 5 entries
    bus.g_wptr = 4'b0111;
    tick();
    tick();
    chk("mid.RD_COUNT", bus.RD_COUNT, 5);
    #2 R_RST = 1'b1;
    model_reset();
    #1;
    chk("mid_rst.RD_COUNT", bus.RD_COUNT, 0);
    chk("mid_rst.EMPTY",    bus.EMPTY,    1'b1);
    tick();
    check_all("mid_in_rst");
    #1 R_RST = 1'b0;
    tick();
    chk("mid_rel1.RD_COUNT", bus.RD_COUNT, 0);
    tick();
    chk("mid_rel2.RD_COUNT", bus.RD_COUNT, 5);
    check_all("mid_rel2");

    // Read and synchronized write land on the same edge
    bus.R_INC  = 1'b1;
    bus.g_wptr = 4'b0100;
    tick();
    chk("same1.RD_COUNT", bus.RD_COUNT, 4);
    tick();
    chk("same2.RD_COUNT", bus.RD_COUNT, 5);
    chk("same2.b_rptr",   bus.b_rptr,   2);
    check_all("same2");
    bus.R_INC = 1'b0;

    // Randomized traffic against the model; writer never exceeds depth
    wbin = 7;
    for (int n = 0; n < 400; n++) begin
      if (($urandom % 3 != 0) && (((wbin - m_rptr + MOD) % MOD) < (MOD / 2)))
        wbin = (wbin + 1) % MOD;
      bus.g_wptr = W'(gray(wbin));
      bus.R_INC  = ($urandom % 2) == 1;
`ifdef FIFO_RD_UNDERFLOW_EN
      bus.UF_CLR = ($urandom % 4) == 0;
`endif
      #1 chk("rnd.RD_VALID", bus.RD_VALID, (bus.R_INC && m_count() != 0));
      tick();
      check_all("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/read_pointer_handler.md
READ_POINTER_HANDLER -- requirements
Module: read_pointer_handler

Interface
REQ-001 PTR_WIDTH, 4, pointer width; FIFO depth = 2^(PTR_WIDTH-1); MSB is the wrap bit.
REQ-002 SYNC_STAGES, 2, number of flops synchronizing g_wptr into the R_CLK domain; minimum 2.
REQ-003 AEMPTY_THRESH, 1, AEMPTY asserts when RD_COUNT <= this value.
REQ-004 R_CLK  input  1  read-domain clock; all state is on the rising edge.
REQ-005 R_RST  input  1  asynchronous, active-high reset.
REQ-006 R_INC  input  1  read request.
REQ-007 g_wptr  input  PTR_WIDTH  Gray-coded write pointer, unsynchronized, from the write domain.
REQ-008 b_rptr  output  PTR_WIDTH  binary read pointer; bits [PTR_WIDTH-2:0] address the RAM.
REQ-009 g_rptr  output  PTR_WIDTH  registered Gray read pointer for crossing to the write domain.
REQ-010 EMPTY  output  1  FIFO empty.
REQ-011 AEMPTY  output  1  FIFO almost empty.
REQ-012 RD_COUNT  output  PTR_WIDTH  occupancy as seen from the read domain, 0..2^(PTR_WIDTH-1).
REQ-013 RD_VALID  output  1  read accepted this cycle.
REQ-014 UF_CLR  input  1  clears UNDERFLOW; present only with FIFO_RD_UNDERFLOW_EN.
REQ-015 UNDERFLOW  output  1  sticky underflow flag; present only with FIFO_RD_UNDERFLOW_EN.

Function
REQ-016 g_wptr SHALL pass through a SYNC_STAGES-deep flop chain; the last stage is g_wptr_sync.
REQ-017 g_wptr_sync SHALL be converted to binary b_wptr_sync by the prefix-XOR rule (bit i = XOR of bits [PTR_WIDTH-1:i]).
REQ-018 RD_VALID SHALL equal R_INC && !EMPTY, combinationally.
REQ-019 On a rising edge with RD_VALID=1, b_rptr SHALL increment by 1 modulo 2^PTR_WIDTH; otherwise b_rptr holds.
REQ-020 g_rptr SHALL be a register loaded on the same edge with gray(b_rptr_next) = next ^ (next >> 1), so g_rptr always equals gray(b_rptr).
REQ-021 RD_COUNT SHALL equal (b_wptr_sync - b_rptr) modulo 2^PTR_WIDTH.
REQ-022 EMPTY SHALL equal (g_rptr == g_wptr_sync), computed only from registered values.
- EMPTY is equivalent to RD_COUNT == 0.
REQ-023 AEMPTY SHALL equal (RD_COUNT <= AEMPTY_THRESH).
REQ-024 A write becomes visible to EMPTY and RD_COUNT exactly SYNC_STAGES R_CLK edges after g_wptr changes; this pessimism is intended.
REQ-025 On wrap-around, b_rptr SHALL go from 2^PTR_WIDTH-1 to 0 and the MSB SHALL toggle; EMPTY and RD_COUNT SHALL remain correct across the wrap.
REQ-026 When R_INC=1 and EMPTY=1, the pointers SHALL NOT change and RD_VALID SHALL be 0.
REQ-027 A read and a synchronized write landing on the same edge SHALL both take effect; RD_COUNT reflects both on the next cycle.

Reset
REQ-028 While R_RST=1, the following SHALL be 0 immediately, independent of R_CLK: b_rptr, g_rptr, all synchronizer flops and UNDERFLOW.
- Consequently EMPTY=1, AEMPTY=1, RD_COUNT=0 and RD_VALID=0.
REQ-029 Reset asserted mid-operation SHALL discard all state, with no partial update on the releasing edge.
REQ-030 After release, g_wptr SHALL be re-synchronized from scratch over SYNC_STAGES edges.

Configuration
REQ-031 With FIFO_RD_UNDERFLOW_EN defined, UNDERFLOW SHALL set on the edge after any cycle with R_INC=1 and EMPTY=1.
- UNDERFLOW stays set until UF_CLR=1 is sampled.
- If set and clear occur in the same cycle, set wins.
REQ-032 Without FIFO_RD_UNDERFLOW_EN, the UF_CLR and UNDERFLOW ports and their logic SHALL be absent, and reads on empty are silently ignored.

Verification (PTR_WIDTH=4, SYNC_STAGES=2, AEMPTY_THRESH=1)
REQ-033 Reset: pulse R_RST asynchronously -> b_rptr=0, g_rptr=0000, EMPTY=1, AEMPTY=1, RD_COUNT=0, UNDERFLOW=0 without waiting for a clock edge.
REQ-034 Latency/drain: hold g_wptr=0010 (gray 3) -> EMPTY drops after exactly 2 edges with RD_COUNT=3, AEMPTY=0; then 3 cycles of R_INC -> b_rptr=3, g_rptr=0010, EMPTY=1, RD_COUNT=0.
REQ-035 Wrap: b_rptr=14, g_wptr=0000 (gray 0, wrapped writer), 2 reads -> b_rptr 14->15->0, g_rptr 1001->1000->0000, EMPTY=1 afterwards.
REQ-036 Full occupancy: b_rptr=0, g_wptr=1100 (gray 8) -> RD_COUNT=8, EMPTY=0, AEMPTY=0.
REQ-037 Underflow (macro on): R_INC=1 while EMPTY=1 -> RD_VALID=0, b_rptr unchanged, UNDERFLOW=1 on the next edge; UF_CLR=1 together with a new underflow -> UNDERFLOW stays 1; UF_CLR=1 alone -> UNDERFLOW=0.
REQ-038 Mid-operation reset: with RD_COUNT=5 and g_wptr=0111 (gray 5), assert R_RST -> RD_COUNT=0 immediately; after release -> RD_COUNT=5 two edges later.
